// File: rtl/rbm_read_master_if.sv
// Signal bundle for rbm_read_master: control, user FIFO port
// and the Avalon-MM pipelined read bus.
interface rbm_read_master_if #(
   parameter int DATAWIDTH     = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     coe_control_fixed_location;
   logic [ADDRESS_WIDTH-1:0] coe_control_read_base;
   logic [ADDRESS_WIDTH-1:0] coe_control_read_length;
   logic                     coe_control_go;
   logic                     coe_control_done;
   logic                     coe_control_early_done;

   logic                     coe_user_read_buffer;
   logic [DATAWIDTH-1:0]     coe_user_buffer_data;
   logic                     coe_user_data_available;

   logic [ADDRESS_WIDTH-1:0] avm_m0_address;
   logic                     avm_m0_read;
   logic [DATAWIDTH/8-1:0]   avm_m0_byteenable;
   logic [DATAWIDTH-1:0]     avm_m0_readdata;
   logic                     avm_m0_readdatavalid;
   logic                     avm_m0_waitrequest;

   modport master (
      input  coe_control_fixed_location,
      input  coe_control_read_base,
      input  coe_control_read_length,
      input  coe_control_go,
      output coe_control_done,
      output coe_control_early_done,
      input  coe_user_read_buffer,
      output coe_user_buffer_data,
      output coe_user_data_available,
      output avm_m0_address,
      output avm_m0_read,
      output avm_m0_byteenable,
      input  avm_m0_readdata,
      input  avm_m0_readdatavalid,
      input  avm_m0_waitrequest
   );

   modport slave (
      output coe_control_fixed_location,
      output coe_control_read_base,
      output coe_control_read_length,
      output coe_control_go,
      input  coe_control_done,
      input  coe_control_early_done,
      output coe_user_read_buffer,
      input  coe_user_buffer_data,
      input  coe_user_data_available,
      input  avm_m0_address,
      input  avm_m0_read,
      input  avm_m0_byteenable,
      output avm_m0_readdata,
      output avm_m0_readdatavalid,
      output avm_m0_waitrequest
   );
endinterface

// File: rtl/rbm_read_master.sv
// Avalon-MM read master: streams a word-aligned region into a
// show-ahead FIFO, throttled so the FIFO can never overflow.
module rbm_read_master #(
   parameter int DATAWIDTH       = 32,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int FIFO_DEPTH      = 32,
   parameter int FIFO_DEPTH_LOG2 = 5
) (
   input logic               clk,
   input logic               reset_n,
   rbm_read_master_if.master bus
);
   localparam int BYTES = DATAWIDTH / 8;
   localparam int L = FIFO_DEPTH_LOG2;
   localparam logic [ADDRESS_WIDTH-1:0] STEP =
      ADDRESS_WIDTH'(BYTES);
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN =
      ~(STEP - 1'b1);
   localparam logic [L+1:0] DEPTH = (L + 2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic                     go_d;
   logic                     fixed;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [ADDRESS_WIDTH-1:0] length;
   logic [L:0]               pending;
   logic [L:0]               count;
   logic [L-1:0]             wr_ptr;
   logic [L-1:0]             rd_ptr;
   logic [DATAWIDTH-1:0]     mem [FIFO_DEPTH];

   logic start;
   logic read;
   logic accept;
   logic push;
   logic pop;

   // Handshake qualifiers; reads stop once FIFO plus in-flight is full
   always_comb begin
      start  = bus.coe_control_go & ~go_d & (state != RUN);
      read   = (state == RUN) && (length != '0) &&
               (({1'b0, count} + {1'b0, pending}) < DEPTH);
      accept = read & ~bus.avm_m0_waitrequest;
      push   = bus.avm_m0_readdatavalid & (pending != '0);
      pop    = bus.coe_user_read_buffer & (count != '0);
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (length == '0 && pending == '0)
                  state_nxt = DONE;
         DONE: if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Transfer parameters, address walk and outstanding-read count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         go_d    <= 1'b0;
         fixed   <= 1'b0;
         address <= '0;
         length  <= '0;
         pending <= '0;
      end else begin
         go_d <= bus.coe_control_go;
         if (start) begin
            fixed   <= bus.coe_control_fixed_location;
            address <= bus.coe_control_read_base & ALIGN;
            length  <= bus.coe_control_read_length & ALIGN;
         end else if (accept) begin
            if (!fixed) address <= address + STEP;
            length <= length - STEP;
         end
         unique case ({accept, push})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
      end
   end

   // FIFO storage; contents are only visible while count is non-zero
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.avm_m0_readdata;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.avm_m0_address          = address;
   assign bus.avm_m0_read             = read;
   assign bus.avm_m0_byteenable       = '1;
   assign bus.coe_control_done        = (state == DONE);
   assign bus.coe_control_early_done  =
      (state != IDLE) && (length == '0);
   assign bus.coe_user_data_available = (count != '0);
   assign bus.coe_user_buffer_data    =
      (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_rbm_read_master.sv
// Bench for rbm_read_master: Avalon slave model, queue-based
// reference model checked every cycle, and directed scenarios.
module tb_rbm_read_master;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 32;

   logic clk;
   logic reset_n;

   rbm_read_master_if #(.DATAWIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   rbm_read_master #(
      .DATAWIDTH(DW),
      .ADDRESS_WIDTH(AW),
      .FIFO_DEPTH(DEPTH),
      .FIFO_DEPTH_LOG2(5)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.master)
   );

   int checks = 0;
   int failures = 0;

   int cyc = 0;
   int lat = 2;
   int acc_total = 0;
   int acc_mark = 0;
   int acc_cyc[$];
   int inject_req = 0;
   int inject_done = 0;
   int rsp_due[$];
   logic [31:0] rsp_dat[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Avalon slave: fixed-latency responses, data = accept index
   initial begin : slave
      bus.avm_m0_readdatavalid = 1'b0;
      bus.avm_m0_readdata = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (inject_done < inject_req) begin
            bus.avm_m0_readdatavalid = 1'b1;
            bus.avm_m0_readdata = 32'hDEAD_BEEF;
            inject_done++;
         end else if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
            bus.avm_m0_readdatavalid = 1'b1;
            bus.avm_m0_readdata = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
         end else begin
            bus.avm_m0_readdatavalid = 1'b0;
            bus.avm_m0_readdata = '0;
         end
         @(negedge clk);
         if (!reset_n) begin
            rsp_due.delete();
            rsp_dat.delete();
         end else if (bus.avm_m0_read && !bus.avm_m0_waitrequest) begin
            acc_total++;
            acc_cyc.push_back(cyc);
            rsp_due.push_back(cyc + lat);
            rsp_dat.push_back(32'(acc_total - acc_mark));
         end
      end
   end

   // Reference model: address list, in-flight count, FIFO queue
   initial begin : cmp
      logic [31:0] exp_addr[$];
      logic [31:0] fifo_q[$];
      logic [31:0] b;
      logic [31:0] prev_addr;
      int m_pend;
      int n;
      bit m_run, m_started, m_go_prev, prev_stall;
      bit acc, psh, pp, strt, fin;
      m_pend = 0;
      m_run = 0;
      m_started = 0;
      m_go_prev = 0;
      prev_stall = 0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("rst_read", bus.avm_m0_read, 0);
            chk("rst_addr", bus.avm_m0_address, 0);
            chk("rst_done", bus.coe_control_done, 0);
            chk("rst_early", bus.coe_control_early_done, 0);
            chk("rst_avail", bus.coe_user_data_available, 0);
            chk("rst_data", bus.coe_user_buffer_data, 0);
            exp_addr.delete();
            fifo_q.delete();
            m_pend = 0;
            m_run = 0;
            m_started = 0;
            m_go_prev = 0;
            prev_stall = 0;
            continue;
         end
         chk("avail", bus.coe_user_data_available, fifo_q.size() != 0);
         if (fifo_q.size() != 0)
            chk("head", bus.coe_user_buffer_data, fifo_q[0]);
         chk("read", bus.avm_m0_read, m_run && exp_addr.size() != 0 &&
             (fifo_q.size() + m_pend) < DEPTH);
         chk("early_done", bus.coe_control_early_done,
             m_started && exp_addr.size() == 0);
         chk("done", bus.coe_control_done, m_started && !m_run);
         if (prev_stall) begin
            chk("stall_read", bus.avm_m0_read, 1);
            chk("stall_addr", bus.avm_m0_address, prev_addr);
         end
         acc = bus.avm_m0_read && !bus.avm_m0_waitrequest;
         if (acc) begin
            if (exp_addr.size() == 0) chk("extra_read", 1, 0);
            else chk("addr", bus.avm_m0_address, exp_addr[0]);
         end
         psh = bus.avm_m0_readdatavalid && m_pend > 0;
         pp = bus.coe_user_read_buffer && fifo_q.size() != 0;
         strt = bus.coe_control_go && !m_go_prev && !m_run;
         fin = m_run && exp_addr.size() == 0 && m_pend == 0;
         prev_stall = bus.avm_m0_read && bus.avm_m0_waitrequest;
         prev_addr = bus.avm_m0_address;
         if (acc && exp_addr.size() != 0) void'(exp_addr.pop_front());
         if (pp) void'(fifo_q.pop_front());
         if (psh) fifo_q.push_back(bus.avm_m0_readdata);
         m_pend = m_pend + (acc ? 1 : 0) - (psh ? 1 : 0);
         if (fin) m_run = 0;
         if (strt) begin
            m_run = 1;
            m_started = 1;
            b = bus.coe_control_read_base & ~32'd3;
            n = int'(bus.coe_control_read_length >> 2);
            for (int i = 0; i < n; i++)
               exp_addr.push_back(bus.coe_control_fixed_location ?
                                  b : b + 32'(4 * i));
         end
         m_go_prev = bus.coe_control_go;
      end
   end

   task automatic start_xfer(input logic [31:0] base,
                             input logic [31:0] len, input bit fx);
      bus.coe_control_read_base = base;
      bus.coe_control_read_length = len;
      bus.coe_control_fixed_location = fx;
      bus.coe_control_go = 1'b1;
      tick();
      bus.coe_control_go = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 500; i++) begin
         if (bus.coe_control_done) break;
         tick();
      end
      chk(name, bus.coe_control_done, 1);
   endtask

   task automatic pop_word(input string name, input logic [31:0] e);
      chk(name, bus.coe_user_buffer_data, e);
      bus.coe_user_read_buffer = 1'b1;
      tick();
      bus.coe_user_read_buffer = 1'b0;
   endtask

   initial begin : main
      int idx0;
      int nxt;
      reset_n = 1'b0;
      bus.coe_control_fixed_location = 1'b0;
      bus.coe_control_read_base = '0;
      bus.coe_control_read_length = '0;
      bus.coe_control_go = 1'b0;
      bus.coe_user_read_buffer = 1'b0;
      bus.avm_m0_waitrequest = 1'b0;
      repeat (3) tick();
      chk("byteenable", bus.avm_m0_byteenable, 64'hF);
      reset_n = 1'b1;
      tick();
      chk("idle_read", bus.avm_m0_read, 0);

      // basic incrementing transfer
      acc_mark = acc_total;
      idx0 = acc_cyc.size();
      start_xfer(32'h1000, 32'd16, 1'b0);
      wait_done("t1_done");
      chk("t1_reads", acc_total - acc_mark, 4);
      chk("t1_consecutive", acc_cyc[idx0 + 3] - acc_cyc[idx0], 3);
      chk("t1_last_addr", acc_cyc.size() - idx0, 4);
      for (int i = 1; i <= 4; i++) pop_word("t1_pop", 32'(i));

      // fixed location
      acc_mark = acc_total;
      start_xfer(32'h20, 32'd12, 1'b1);
      wait_done("t2_done");
      chk("t2_reads", acc_total - acc_mark, 3);
      chk("t2_addr", bus.avm_m0_address, 32'h20);
      for (int i = 1; i <= 3; i++) pop_word("t2_pop", 32'(i));

      // unaligned base and length are truncated to words
      acc_mark = acc_total;
      start_xfer(32'h103, 32'd7, 1'b0);
      wait_done("ta_done");
      chk("ta_reads", acc_total - acc_mark, 1);
      pop_word("ta_pop", 32'd1);

      // zero length
      acc_mark = acc_total;
      start_xfer(32'h500, 32'd0, 1'b0);
      chk("tz_run", bus.coe_control_done, 0);
      chk("tz_early", bus.coe_control_early_done, 1);
      tick();
      chk("tz_done", bus.coe_control_done, 1);
      chk("tz_reads", acc_total - acc_mark, 0);

      // FIFO full throttling, 64 words
      acc_mark = acc_total;
      start_xfer(32'h0, 32'd256, 1'b0);
      repeat (100) tick();
      chk("t3_reads_full", acc_total - acc_mark, 32);
      chk("t3_read_low", bus.avm_m0_read, 0);
      pop_word("t3_pop", 32'd1);
      repeat (10) tick();
      chk("t3_reads_one", acc_total - acc_mark, 33);
      nxt = 2;
      for (int i = 0; i < 3000 && nxt <= 64; i++) begin
         if (bus.coe_user_data_available) begin
            chk("t3_pop", bus.coe_user_buffer_data, 32'(nxt));
            nxt++;
            bus.coe_user_read_buffer = 1'b1;
         end else begin
            bus.coe_user_read_buffer = 1'b0;
         end
         tick();
      end
      bus.coe_user_read_buffer = 1'b0;
      chk("t3_words", nxt, 65);
      wait_done("t3_done");

      // waitrequest stall on first read
      bus.avm_m0_waitrequest = 1'b1;
      acc_mark = acc_total;
      start_xfer(32'h40, 32'd8, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("t4_read", bus.avm_m0_read, 1);
         chk("t4_addr", bus.avm_m0_address, 32'h40);
         chk("t4_early", bus.coe_control_early_done, 0);
         tick();
      end
      bus.avm_m0_waitrequest = 1'b0;
      wait_done("t4_done");
      chk("t4_reads", acc_total - acc_mark, 2);
      pop_word("t4_pop", 32'd1);
      pop_word("t4_pop", 32'd2);

      // go held high does not restart
      acc_mark = acc_total;
      bus.coe_control_read_base = 32'h80;
      bus.coe_control_read_length = 32'd4;
      bus.coe_control_fixed_location = 1'b0;
      bus.coe_control_go = 1'b1;
      tick();
      wait_done("t5_done");
      repeat (10) tick();
      chk("t5_reads_held", acc_total - acc_mark, 1);
      chk("t5_done_held", bus.coe_control_done, 1);
      bus.coe_control_go = 1'b0;
      tick();
      bus.coe_control_go = 1'b1;
      tick();
      chk("t5_done_drop", bus.coe_control_done, 0);
      bus.coe_control_go = 1'b0;
      wait_done("t5_done2");
      chk("t5_reads", acc_total - acc_mark, 2);
      pop_word("t5_pop", 32'd1);
      pop_word("t5_pop", 32'd2);

      // reset with three reads in flight, then stray responses
      lat = 20;
      acc_mark = acc_total;
      start_xfer(32'h200, 32'd12, 1'b0);
      for (int i = 0; i < 50; i++) begin
         if (acc_total - acc_mark >= 3) break;
         tick();
      end
      chk("t6_issued", acc_total - acc_mark, 3);
      tick();
      reset_n = 1'b0;
      #1;
      chk("t6_rst_read", bus.avm_m0_read, 0);
      chk("t6_rst_addr", bus.avm_m0_address, 0);
      chk("t6_rst_early", bus.coe_control_early_done, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      lat = 2;
      inject_req = inject_req + 3;
      repeat (6) tick();
      chk("t6_avail", bus.coe_user_data_available, 0);
      chk("t6_data", bus.coe_user_buffer_data, 0);
      chk("t6_done", bus.coe_control_done, 0);
      chk("t6_early", bus.coe_control_early_done, 0);
      chk("t6_read", bus.avm_m0_read, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rbm_read_master.md
RBM_READ_MASTER -- requirements
Module: rbm_read_master

Interface
REQ-001 Parameters SHALL be: DATAWIDTH, 32, read data width in bits; ADDRESS_WIDTH, 32, byte address and length width; FIFO_DEPTH, 32, read FIFO words; FIFO_DEPTH_LOG2, 5, log2 of FIFO_DEPTH.
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 coe_control_fixed_location  in  1  hold address constant; coe_control_read_base  in  ADDRESS_WIDTH  start byte address; coe_control_read_length  in  ADDRESS_WIDTH  transfer bytes; coe_control_go  in  1  start request (level, edge-detected).
REQ-004 coe_control_done  out  1  transfer complete; coe_control_early_done  out  1  all reads issued.
REQ-005 coe_user_read_buffer  in  1  pop FIFO; coe_user_buffer_data  out  DATAWIDTH  FIFO head; coe_user_data_available  out  1  FIFO non-empty.
REQ-006 avm_m0_address  out  ADDRESS_WIDTH; avm_m0_read  out  1; avm_m0_byteenable  out  DATAWIDTH/8; avm_m0_readdata  in  DATAWIDTH; avm_m0_readdatavalid  in  1; avm_m0_waitrequest  in  1 -- Avalon-MM pipelined read master, no bursts.

Function
REQ-007 State machine SHALL have states IDLE, RUN, DONE.
REQ-008 Start SHALL occur on go rising edge (go=1 this cycle, registered go_d=0) while in IDLE or DONE; base, length, fixed_location latched at that edge; state -> RUN.
REQ-009 go edge while in RUN SHALL be ignored; go held high SHALL NOT restart a transfer.
REQ-010 Length low log2(DATAWIDTH/8) bits and base low log2(DATAWIDTH/8) bits SHALL be treated as zero.
REQ-011 avm_m0_read SHALL be 1 only when state=RUN, remaining length!=0, and fifo_used + pending < FIFO_DEPTH.
REQ-012 Read accepted (read & !waitrequest): address += DATAWIDTH/8 (unchanged if fixed_location), remaining length -= DATAWIDTH/8, pending += 1; address/read SHALL stay stable while waitrequest=1.
REQ-013 avm_m0_byteenable SHALL be all ones.
REQ-014 readdatavalid while pending>0: readdata written to FIFO, pending -= 1; accept and response in same cycle leave pending unchanged.
REQ-015 readdatavalid with pending=0 SHALL be ignored.
REQ-016 FIFO SHALL be show-ahead: word written at edge t visible on coe_user_buffer_data with data_available=1 from t+1.
REQ-017 Pop when read_buffer=1 and data_available=1; read_buffer on empty FIFO SHALL be ignored; simultaneous push and pop SHALL keep count unchanged.
REQ-018 FIFO overflow SHALL be impossible by REQ-011 (pending counter width FIFO_DEPTH_LOG2+1).
REQ-019 early_done SHALL be 1 when state in {RUN, DONE} and remaining length=0.
REQ-020 RUN -> DONE when remaining length=0 and pending=0; done SHALL be 1 in DONE only, held until next start.
REQ-021 Length 0 at start: RUN one cycle, no reads, DONE the following cycle.
REQ-022 FIFO contents SHALL persist across DONE -> RUN (not flushed by start).

Reset
REQ-023 reset_n=0 SHALL asynchronously force: state IDLE, go_d 0, address 0, length 0, pending 0, FIFO empty; outputs read 0, done 0, early_done 0, data_available 0, buffer_data 0, address 0.
REQ-024 Responses arriving after reset mid-transfer SHALL be dropped (REQ-015).

Verification
REQ-025 base 0x1000, length 16, waitrequest 0, response latency 2, data 1,2,3,4 -> addresses 0x1000,0x1004,0x1008,0x100C on consecutive cycles; early_done after 4th accept; done after 4th response; pops yield 1,2,3,4.
REQ-026 fixed_location=1, base 0x20, length 12 -> exactly 3 reads, all at 0x20; done asserted.
REQ-027 length 256 (64 words), user never pops -> exactly 32 reads issued then read=0; popping 1 word enables exactly 1 further read; all 64 words delivered in order.
REQ-028 waitrequest=1 for 5 cycles on first read -> address/read stable, length unchanged, pending 0, until accept.
REQ-029 go held high continuously after completion -> no second transfer; go low then high -> new transfer, done drops cycle after start edge.
REQ-030 reset_n low mid-transfer with 3 reads pending, then 3 late readdatavalid -> all outputs per REQ-023, FIFO stays empty, state IDLE.
